// File: rtl/dmem_responder_pkg.sv
// Shared address map and STATUS register layout for the data-memory responder.
package arm_mem_pkg;

  localparam logic [31:0] ADDR_GPIO    = 32'h0000_0400;
  localparam logic [31:0] ADDR_CYCLE   = 32'h0000_0404;
  localparam logic [31:0] ADDR_TX_DATA = 32'h0000_0408;
  localparam logic [31:0] ADDR_STATUS  = 32'h0000_040C;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 4;
  localparam int STATUS_COUNT_MSB = 7;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_GPIO,
    RGN_CYCLE,
    RGN_TX,
    RGN_STATUS,
    RGN_NONE
  } region_e;

  // Takes the word address (byte address bits [31:2]); byte-lane bits never matter.
  function automatic region_e decode_region(input logic [29:0] word_addr);
    region_e r;
    r = RGN_NONE;
    if (word_addr[29:8] == 22'd0)               r = RGN_RAM;
    else if (word_addr == ADDR_GPIO[31:2])      r = RGN_GPIO;
    else if (word_addr == ADDR_CYCLE[31:2])     r = RGN_CYCLE;
    else if (word_addr == ADDR_TX_DATA[31:2])   r = RGN_TX;
    else if (word_addr == ADDR_STATUS[31:2])    r = RGN_STATUS;
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core load/store bus plus the outgoing TX word stream of the responder.
interface dmem_responder_if;

  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  // TX stream: a word transfers on every rising edge where tx_valid && tx_ready;
  // tx_valid never depends on tx_ready, and tx_data holds while tx_valid && !tx_ready.
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;

  modport master (
    output MemWrite, ALUResult, WriteData, tx_ready,
    input  ReadData, tx_valid, tx_data
  );

  modport slave (
    input  MemWrite, ALUResult, WriteData, tx_ready,
    output ReadData, tx_valid, tx_data
  );

endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// Word FIFO feeding the TX stream; a push into a full FIFO is taken only if a pop frees a slot.
module tx_fifo #(
  parameter  int FIFO_DEPTH = 4,
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [31:0]   head
);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset && do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-cycle data-memory responder: RAM, GPIO, free-running cycle counter and a TX FIFO.
module dmem_responder
  import arm_mem_pkg::*;
#(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  dmem_responder_if.slave         bus,
  output logic [31:0]             gpio_out
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  region_e       region;
  logic [7:0]    ram_idx;
  logic          ram_hit;
  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cycle_q;
  logic          overflow_q;
  logic          push_req;
  logic          push_drop;
  logic          ovf_clear;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_head;
  logic [31:0]   status_word;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^bus.ALUResult[1:0];

  assign region  = decode_region(bus.ALUResult[31:2]);
  assign ram_idx = bus.ALUResult[9:2];
  // Word indices beyond the populated RAM read as zero and swallow writes.
  assign ram_hit = (region == RGN_RAM) && ((ram_idx >> RAM_AW) == 8'd0);

  assign push_req  = bus.MemWrite && (region == RGN_TX);
  assign fifo_pop  = !fifo_empty && bus.tx_ready;
  assign push_drop = push_req && fifo_full && !fifo_pop;
  assign fifo_push = push_req && !push_drop;
  assign ovf_clear = bus.MemWrite && (region == RGN_STATUS) && bus.WriteData[STATUS_OVF_BIT];

  tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.WriteData),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_head;

  always_comb begin
    status_word = '0;
    status_word[STATUS_EMPTY_BIT] = fifo_empty;
    status_word[STATUS_FULL_BIT]  = fifo_full;
    status_word[STATUS_OVF_BIT]   = overflow_q;
    status_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 4'(fifo_count);
  end

  always_comb begin
    bus.ReadData = '0;
    case (region)
      RGN_RAM:    bus.ReadData = ram_hit ? ram[ram_idx[RAM_AW-1:0]] : '0;
      RGN_GPIO:   bus.ReadData = gpio_out;
      RGN_CYCLE:  bus.ReadData = cycle_q;
      RGN_STATUS: bus.ReadData = status_word;
      default:    bus.ReadData = '0;
    endcase
  end

  // RAM keeps its contents through reset but ignores stores while reset is held.
  always_ff @(posedge clk) begin
    if (reset && bus.MemWrite && ram_hit) ram[ram_idx[RAM_AW-1:0]] <= bus.WriteData;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gpio_out   <= '0;
      cycle_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.MemWrite && (region == RGN_GPIO)) gpio_out <= bus.WriteData;
      if (bus.MemWrite && (region == RGN_CYCLE)) cycle_q <= bus.WriteData;
      else                                       cycle_q <= cycle_q + 32'd1;
      // A dropped push on the same edge as a clear leaves the flag set.
      if (push_drop)      overflow_q <= 1'b1;
      else if (ovf_clear) overflow_q <= 1'b0;
    end
  end

endmodule
